// File: rtl/ex_mem_pkg.sv
// Shared entry layout for the execute->memory buffer.
// Entry widths follow the core defaults. The top's width parameters must match these defaults.
package ex_mem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 20;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/fifo2.sv
// Generic 2-entry in-order FIFO. Head and tail are exposed for bypass taps.
// clear overrides push/pop; push when full and pop when empty are ignored.
module fifo2 #(
  parameter int ENTRY_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_dat,
  output logic [1:0]         count,
  output logic [ENTRY_W-1:0] head_dat,
  output logic [ENTRY_W-1:0] tail_dat
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  assign do_push = push && (count_q != 2'd2);
  assign do_pop  = pop && (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      mem_d[0] = '0;
      mem_d[1] = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  // Tail is the younger entry; meaningful only when count == 2.
  assign tail_dat = mem_q[~rd_ptr_q];

endmodule

// File: rtl/execute_memory_pipe.sv
// Execute->memory stage: 2-entry result buffer, taken-branch redirect, flush squash.
// Define EX_BYPASS_EN to drive the fwd0 (head) and fwd1 (tail) bypass taps; otherwise they are tied to 0.
module execute_memory_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int ADDRESS_BITS  = ADDR_W,
  parameter int REG_ADDR_BITS = REG_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [DATA_WIDTH-1:0]    ex_ALU_result,
  input  logic                     ex_branch,
  input  logic                     ex_jump,
  input  logic [ADDRESS_BITS-1:0]  ex_target,
  input  logic [DATA_WIDTH-1:0]    ex_store_data,
  input  logic [REG_ADDR_BITS-1:0] ex_rd,
  input  logic                     ex_regWrite,
  input  logic                     ex_memRead,
  input  logic                     ex_memWrite,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [DATA_WIDTH-1:0]    mem_ALU_result,
  output logic [DATA_WIDTH-1:0]    mem_store_data,
  output logic [REG_ADDR_BITS-1:0] mem_rd,
  output logic                     mem_regWrite,
  output logic                     mem_memRead,
  output logic                     mem_memWrite,
  output logic                     redirect_valid,
  output logic [ADDRESS_BITS-1:0]  redirect_pc,
  input  logic                     flush,
  output logic                     fwd0_valid,
  output logic                     fwd1_valid,
  output logic [REG_ADDR_BITS-1:0] fwd0_rd,
  output logic [REG_ADDR_BITS-1:0] fwd1_rd,
  output logic [DATA_WIDTH-1:0]    fwd0_data,
  output logic [DATA_WIDTH-1:0]    fwd1_data
);

  logic                    redirect_valid_q, redirect_valid_d;
  logic [ADDRESS_BITS-1:0] redirect_pc_q, redirect_pc_d;
  logic [1:0]              count;
  logic                    enq, deq;
  entry_t                  push_ent, head_raw, head;
`ifdef EX_BYPASS_EN
  entry_t                  tail_raw;
`endif

  assign ex_ready  = (count != 2'd2) && !redirect_valid_q;
  assign enq       = ex_valid && ex_ready;
  assign mem_valid = (count != 2'd0);
  assign deq       = mem_valid && mem_ready;

  always_comb begin
    push_ent            = '0;
    push_ent.alu_result = ex_ALU_result;
    push_ent.store_data = ex_store_data;
    push_ent.rd         = ex_rd;
    push_ent.reg_write  = ex_regWrite;
    push_ent.mem_read   = ex_memRead;
    push_ent.mem_write  = ex_memWrite;
  end

  fifo2 #(.ENTRY_W(ENTRY_W)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (flush),
    .push     (enq),
    .pop      (deq),
    .push_dat (push_ent),
    .count    (count),
`ifdef EX_BYPASS_EN
    .tail_dat (tail_raw),
`else
    .tail_dat (),
`endif
    .head_dat (head_raw)
  );

  // Outputs read 0 whenever the head is empty, so popped entries never leak out.
  assign head           = mem_valid ? head_raw : '0;
  assign mem_ALU_result = head.alu_result;
  assign mem_store_data = head.store_data;
  assign mem_rd         = head.rd;
  assign mem_regWrite   = head.reg_write;
  assign mem_memRead    = head.mem_read;
  assign mem_memWrite   = head.mem_write;

  // The redirect pulse lasts exactly one cycle; it also blocks ex_ready for that cycle.
  always_comb begin
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    if (!flush && enq && (ex_branch || ex_jump)) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = ex_target;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef EX_BYPASS_EN
  always_comb begin
    fwd0_valid = mem_valid && head_raw.reg_write && (head_raw.rd != '0);
    fwd0_rd    = head.rd;
    fwd0_data  = head.alu_result;
    fwd1_valid = (count == 2'd2) && tail_raw.reg_write && (tail_raw.rd != '0);
    fwd1_rd    = (count == 2'd2) ? tail_raw.rd : '0;
    fwd1_data  = (count == 2'd2) ? tail_raw.alu_result : '0;
  end
`else
  always_comb begin
    fwd0_valid = 1'b0;
    fwd0_rd    = '0;
    fwd0_data  = '0;
    fwd1_valid = 1'b0;
    fwd1_rd    = '0;
    fwd1_data  = '0;
  end
`endif

endmodule

// File: doc/execute_memory_pipe.md
# execute_memory_pipe

Pipeline stage between the ALU/execute stage and the data-memory stage of the BRISC-V core. It registers each executed instruction's result into a 2-entry buffer and presents it downstream with a valid/ready handshake. It also turns taken branches and jumps into a one-cycle front-end redirect, and squashes its contents on a pipeline flush.

## Interface
- DATA_WIDTH, 32: operand/result width
- ADDRESS_BITS, 20: PC/target width
- REG_ADDR_BITS, 5: register index width
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  block accepts this cycle
- ex_ALU_result  in  DATA_WIDTH  ALU result (PC+4 for JAL/JALR)
- ex_branch  in  1  ALU branch-taken flag
- ex_jump  in  1  JAL/JALR
- ex_target  in  ADDRESS_BITS  branch/jump target
- ex_store_data  in  DATA_WIDTH  rs2 value for stores
- ex_rd  in  REG_ADDR_BITS  destination register
- ex_regWrite, ex_memRead, ex_memWrite  in  1 each  control bits
- mem_valid  out  1  head entry valid
- mem_ready  in  1  memory stage takes the head entry
- mem_ALU_result, mem_store_data  out  DATA_WIDTH  head entry fields
- mem_rd  out  REG_ADDR_BITS; mem_regWrite, mem_memRead, mem_memWrite  out  1 each
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  ADDRESS_BITS  redirect target
- flush  in  1  synchronous squash from a later stage
- fwd0_valid, fwd1_valid  out  1; fwd0_rd, fwd1_rd  out  REG_ADDR_BITS; fwd0_data, fwd1_data  out  DATA_WIDTH  bypass (head, tail)

## Operation
- Entries are stored in a 2-entry in-order FIFO. The occupancy count is 0..2.
- Enqueue occurs when ex_valid && ex_ready.
- Dequeue occurs when mem_valid && mem_ready.
- ex_ready = (count != 2) && !redirect_valid. It does not depend on ex_valid or on mem_ready.
- When count == 1, simultaneous enqueue and dequeue are both permitted, and count stays 1.
- mem_* outputs show the head entry. mem_valid = (count != 0).
- An enqueue with ex_branch || ex_jump arms redirect. On the next cycle:
  - redirect_valid = 1 and redirect_pc = the captured ex_target.
  - ex_ready = 0, so the wrong-path instruction is not accepted.
  - Upstream clears on redirect_valid.
  - The branch/jump entry itself is enqueued normally.
- Not-taken branches (ex_branch = 0, ex_jump = 0) never redirect.
- flush clears both entries and any armed redirect on the next edge.
  - It overrides a simultaneous enqueue, dequeue, or redirect arm.
  - mem_valid = 0 on the following cycle.
- Reset clears count, both entries, and the redirect state asynchronously.

## Timing
- Latency: an accept at edge N gives mem_valid = 1 after edge N when the buffer was empty.
- Throughput: 1 per cycle while mem_ready = 1 and no redirect occurs.
- Redirect costs exactly one ex_ready = 0 bubble.
- Values during and immediately after reset:
  - ex_ready = 1
  - mem_valid = 0, and all mem_* = 0
  - redirect_valid = 0, redirect_pc = 0
  - all fwd* = 0
- A full buffer holds its entries indefinitely while mem_ready = 0. Entries are never dropped or reordered.
- The write pointer wraps modulo 2. A read pointer/count mismatch cannot occur.

## Configuration
- EX_BYPASS_EN:
  - When defined:
    - fwd0_* reflect the head entry and fwd1_* the tail entry.
    - fwdN_valid = entry valid && regWrite && (rd != 0).
  - When undefined:
    - The fwd* ports remain present and are tied to 0.
    - No bypass logic is synthesised.

## Structure
- Package ex_mem_pkg holds:
  - the entry struct (ALU_result, store_data, rd, regWrite, memRead, memWrite)
  - its ENTRY_W width constant
- Sub-module fifo2 is a generic 2-entry FIFO (push, pop, count, head/tail data) parameterised by ENTRY_W.
- Redirect and flush logic live in the top module.

## Test plan
- Single ALU op: after reset, push result 0x0000_0005 with rd = 3 and regWrite = 1, mem_ready = 1 -> the next cycle shows mem_valid = 1, mem_ALU_result = 0x5, mem_rd = 3, and ex_ready stays 1.
- Backpressure: with mem_ready = 0, push A, B, C -> ex_ready = 0 after B and C is held upstream. Then set mem_ready = 1 -> A, B, C emerge in order, one per cycle.
- Taken branch: push with ex_branch = 1 and ex_target = 0x00100 -> the next cycle has redirect_valid = 1, redirect_pc = 0x00100, ex_ready = 0. The cycle after has redirect_valid = 0.
- Flush: with the buffer full, assert flush together with ex_valid and a jump -> the next cycle has mem_valid = 0, count 0, no redirect, and ex_ready = 1.
- Reset mid-operation: with 1 entry held and a redirect armed, assert reset asynchronously -> mem_valid, redirect_valid, and all fwd* go to 0 immediately.
- Bypass (EX_BYPASS_EN): push rd = 7 with data 0xDEADBEEF -> fwd0_valid = 1, fwd0_rd = 7, fwd0_data = 0xDEADBEEF. A push with rd = 0 gives fwd0_valid = 0. Without the macro, all fwd* read 0.
